// File: rtl/strided_buffer_rd.sv
// Read side of the strided slice buffer: walks stride-1 windows
// over N_BUF_X BRAMs, rotates lanes and streams beats out.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   dshape, start      shape word {w_i,h_i,c_i}, pass start pulse
//   busy, done         pass in progress, end-of-pass pulse
//   rdaddr, di         per-BRAM read address / read data (1-cycle)
//   dout, dout_valid,
//   dout_ready         window beat stream, lane 0 = first slice
module strided_buffer_rd #(
  parameter int N_BUF_X    = 5,
  parameter int B_DSHAPE   = 48,
  parameter int DATA_WIDTH = 64,
  parameter int B_BUF_ADDR = 10
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [B_DSHAPE-1:0]            dshape,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [N_BUF_X*B_BUF_ADDR-1:0]  rdaddr,
  input  logic [DATA_WIDTH*N_BUF_X-1:0]  di,
  output logic [DATA_WIDTH*N_BUF_X-1:0]  dout,
  output logic                           dout_valid,
  input  logic                           dout_ready
);

  localparam int RW = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;
  localparam int BW = DATA_WIDTH * N_BUF_X;
  localparam int AW = B_BUF_ADDR;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [15:0] c_i, h_i, w_i;
  logic [15:0] n_eps_calc, n_win_calc;
  logic        empty;

  logic [15:0] n_eps_q, n_win_q;
  logic [15:0] e_q, s_q;
  logic [RW-1:0] rot_q, infl_rot_q;
  logic [AW-1:0] base_q [N_BUF_X];
  logic [N_BUF_X*AW-1:0] rdaddr_q, rdaddr_cur;
  logic          infl_q;

  logic [BW-1:0] fifo_q [2];
  logic          wp_q, rp_q;
  logic [1:0]    occ_q;

  logic          pop, issue, last_e, last;
  logic [2:0]    level;
  logic [BW-1:0] rot_data;

  assign c_i = dshape[15:0];
  assign h_i = dshape[31:16];
  assign w_i = dshape[47:32];

  assign n_eps_calc = (c_i >> 6) * h_i;
  assign n_win_calc = w_i - 16'(N_BUF_X) + 16'd1;
  assign empty = (n_eps_calc == 16'd0) ||
                 (w_i < 16'(N_BUF_X));

  assign dout_valid = (occ_q != 2'd0);
  assign dout       = fifo_q[rp_q];
  assign pop        = dout_valid & dout_ready;

  // Reads not yet consumed after this cycle: keep at most 2.
  assign level = {1'b0, occ_q} + {2'b0, infl_q}
               - {2'b0, pop};
  assign issue = (state_q == S_RUN) && (level < 3'd2);

  assign last_e = (e_q == n_eps_q - 16'd1);
  assign last   = last_e && (s_q == n_win_q - 16'd1);

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_FIN);

  always_comb begin
    rdaddr_cur = '0;
    for (int b = 0; b < N_BUF_X; b++) begin
      rdaddr_cur[b*AW +: AW] = base_q[b] + AW'(e_q);
    end
  end

  assign rdaddr = issue ? rdaddr_cur : rdaddr_q;

  // Lane j of the returning beat comes from BRAM (s+j) mod N.
  always_comb begin
    int k;
    rot_data = '0;
    for (int j = 0; j < N_BUF_X; j++) begin
      k = int'(infl_rot_q) + j;
      if (k >= N_BUF_X) k = k - N_BUF_X;
      rot_data[j*DATA_WIDTH +: DATA_WIDTH] =
        di[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = empty ? S_FIN : S_RUN;
      S_RUN:   if (issue && last) state_d = S_DRAIN;
      S_DRAIN: if (level == 3'd0) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      n_eps_q    <= '0;
      n_win_q    <= '0;
      e_q        <= '0;
      s_q        <= '0;
      rot_q      <= '0;
      infl_rot_q <= '0;
      infl_q     <= 1'b0;
      rdaddr_q   <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      occ_q      <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      for (int b = 0; b < N_BUF_X; b++) begin
        base_q[b] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rdaddr_q <= rdaddr;
      infl_q   <= issue;
      if (issue) infl_rot_q <= rot_q;

      if (state_q == S_IDLE && start) begin
        n_eps_q <= n_eps_calc;
        n_win_q <= n_win_calc;
        e_q     <= '0;
        s_q     <= '0;
        rot_q   <= '0;
        for (int b = 0; b < N_BUF_X; b++) begin
          base_q[b] <= '0;
        end
      end else if (issue) begin
        if (last_e) begin
          // Slice s leaves BRAM rot; slice s+N takes its place
          // one n_eps-sized block further down.
          e_q <= '0;
          s_q <= s_q + 16'd1;
          for (int b = 0; b < N_BUF_X; b++) begin
            if (RW'(b) == rot_q) begin
              base_q[b] <= base_q[b] + AW'(n_eps_q);
            end
          end
          if (rot_q == RW'(N_BUF_X - 1)) rot_q <= '0;
          else rot_q <= rot_q + RW'(1);
        end else begin
          e_q <= e_q + 16'd1;
        end
      end

      if (infl_q) begin
        fifo_q[wp_q] <= rot_data;
        wp_q         <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      occ_q <= occ_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_strided_buffer_rd.sv
// Bench for strided_buffer_rd: BRAM model, vector table of passes
// plus hand-written restart and mid-pass reset sequences.
module tb_strided_buffer_rd;

  localparam int N  = 5;
  localparam int DW = 64;
  localparam int BA = 10;
  localparam int BD = 48;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [BD-1:0]   dshape = '0;
  logic            start = 1'b0;
  logic            busy, done;
  logic [N*BA-1:0] rdaddr;
  logic [DW*N-1:0] di;
  logic [DW*N-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;

  strided_buffer_rd #(
    .N_BUF_X(N), .B_DSHAPE(BD),
    .DATA_WIDTH(DW), .B_BUF_ADDR(BA)
  ) dut (
    .clk(clk), .rstn(rstn), .dshape(dshape), .start(start),
    .busy(busy), .done(done), .rdaddr(rdaddr), .di(di),
    .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [N][1024];
  always @(posedge clk) begin
    for (int b = 0; b < N; b++)
      di[b*DW +: DW] <= mem[b][rdaddr[b*BA +: BA]];
  end

  logic       tog_en = 1'b0;
  logic [1:0] tog_idx = '0;
  logic [3:0] pat = 4'b1001;
  always @(posedge clk) tog_idx <= tog_idx + 2'd1;
  assign dout_ready = tog_en ? pat[tog_idx] : 1'b1;

  logic [DW*N-1:0] beats [$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic busy_at_done = 1'b0;
  logic pv = 1'b0, pr = 1'b1;
  logic [DW*N-1:0] pd = '0;

  always @(negedge clk) begin
    if (rstn && pv && !pr) begin
      checks++;
      if (!(dout_valid && dout == pd)) begin
        failures++;
        $display("FAIL stall_hold t=%0d got v=%0b %h want v=1 %h",
                 cyc, dout_valid, dout, pd);
      end
    end
    if (dout_valid && dout_ready) beats.push_back(dout);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    pv = dout_valid;
    pr = dout_ready;
    pd = dout;
  end

  task automatic chki(input string nm, input int act,
                      input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic [DW*N-1:0] act,
                      input logic [DW*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int neps_of(input logic [15:0] c,
                                 input logic [15:0] h);
    return int'((c >> 6) * h) & 65535;
  endfunction

  task automatic preload(input logic [15:0] c,
                         input logic [15:0] h,
                         input logic [15:0] w);
    int ne;
    ne = neps_of(c, h);
    for (int b = 0; b < N; b++)
      for (int a = 0; a < 1024; a++)
        mem[b][a] = 64'hDEAD_0000_0000_0000;
    for (int k = 0; k < int'(w); k++)
      for (int e = 0; e < ne; e++)
        mem[k % N][((k / N) * ne + e) % 1024] = 64'(k * 256 + e);
  endtask

  function automatic logic [DW*N-1:0] exp_beat(input int i,
                                               input int ne);
    logic [DW*N-1:0] r;
    int s, e;
    s = i / ne;
    e = i % ne;
    r = '0;
    for (int j = 0; j < N; j++)
      r[j*DW +: DW] = 64'((s + j) * 256 + e);
    return r;
  endfunction

  int c0;

  task automatic pulse_start(input logic [15:0] c,
                             input logic [15:0] h,
                             input logic [15:0] w);
    @(posedge clk);
    #1;
    dshape = {w, h, c};
    start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_pass(input string nm,
                          input logic [15:0] c,
                          input logic [15:0] h,
                          input logic [15:0] w,
                          input bit tog, input bit restart,
                          input int nb, input int lat);
    int d0, t, n;
    preload(c, h, w);
    tog_en = tog;
    beats.delete();
    d0 = done_cnt;
    pulse_start(c, h, w);
    if (restart) begin
      repeat (2) @(posedge clk);
      #1;
      dshape = {16'd12, 16'd3, 16'd128};
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chki({nm, "_done_seen"}, int'(done_cnt != d0), 1);
    if (lat > 0) chki({nm, "_done_lat"}, done_cyc - c0, lat);
    chki({nm, "_busy_at_done"}, int'(busy_at_done), 1);
    @(negedge clk);
    chki({nm, "_idle_after"}, int'({busy, dout_valid}), 0);
    chki({nm, "_beats"}, beats.size(), nb);
    n = (beats.size() < nb) ? beats.size() : nb;
    for (int i = 0; i < n; i++)
      chkb($sformatf("%s_beat%0d", nm, i), beats[i],
           exp_beat(i, neps_of(c, h)));
    tog_en = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic [15:0] c, h, w;
    bit          tog, restart;
    int          nb, lat;
  } vec_t;

  vec_t v [7];

  initial begin
    int dn, t;
    v[0] = '{"base",     16'd64,  16'd2, 16'd7,  0, 0, 6,  9};
    v[1] = '{"toggle",   16'd64,  16'd2, 16'd7,  1, 0, 6,  0};
    v[2] = '{"w_small",  16'd64,  16'd2, 16'd4,  0, 0, 0,  1};
    v[3] = '{"neps0",    16'd32,  16'd2, 16'd7,  0, 0, 0,  1};
    v[4] = '{"wide",     16'd128, 16'd3, 16'd12, 0, 0, 48, 51};
    v[5] = '{"single",   16'd64,  16'd1, 16'd5,  0, 0, 1,  4};
    v[6] = '{"restart",  16'd64,  16'd2, 16'd7,  0, 1, 6,  9};

    for (int b = 0; b < N; b++)
      for (int a = 0; a < 1024; a++)
        mem[b][a] = '0;

    repeat (2) @(negedge clk);
    chki("rst_ctrl", int'({busy, done, dout_valid}), 0);
    chkb("rst_dout", dout, '0);
    chki("rst_rdaddr", int'(rdaddr != '0), 0);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++)
      run_pass(v[i].nm, v[i].c, v[i].h, v[i].w,
               v[i].tog, v[i].restart, v[i].nb, v[i].lat);

    preload(16'd64, 16'd2, 16'd7);
    beats.delete();
    pulse_start(16'd64, 16'd2, 16'd7);
    t = 0;
    while (beats.size() < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chki("rst_mid_reach3", int'(beats.size() >= 3), 1);
    dn = done_cnt;
    rstn = 1'b0;
    @(negedge clk);
    chki("rst_mid_state", int'({dout_valid, busy, done}), 0);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    chki("rst_mid_nodone", done_cnt - dn, 0);
    chki("rst_mid_valid", int'(dout_valid), 0);

    run_pass("replay", 16'd64, 16'd2, 16'd7, 0, 0, 6, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
